// File: rtl/bus_defs.sv
// Shared definitions for the internal-bus arbiter: source indices and FSM encoding.
package bus_defs;

    localparam int unsigned N_REQ = 8;

    localparam int unsigned SRC_AR  = 0;
    localparam int unsigned SRC_PC  = 1;
    localparam int unsigned SRC_DR  = 2;
    localparam int unsigned SRC_AC  = 3;
    localparam int unsigned SRC_IR  = 4;
    localparam int unsigned SRC_TR  = 5;
    localparam int unsigned SRC_MEM = 6;
    localparam int unsigned SRC_IO  = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus sources and the arbiter.
interface bus_arbiter_if #(
    parameter int unsigned N_REQ = bus_defs::N_REQ
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic             timeout;

    modport master (
        input  req,
        output grant,
        output grant_id,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        input  grant,
        input  grant_id,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 8,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             found_o,
    output logic [ID_W-1:0]  winner_o
);
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            int unsigned idx;
            idx = int'(ptr_i) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared 8-bit internal bus with registered one-hot grant and hold timeout.
module bus_arbiter
    import bus_defs::*;
#(
    parameter int unsigned N_REQ    = bus_defs::N_REQ,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             found;
    logic [ID_W-1:0]  winner;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .found_o  (found),
        .winner_o (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        id_d      = id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    id_d            = winner;
                    busy_d          = 1'b1;
                    ptr_d           = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
                    cnt_d           = CNT_W'(1);
                    state_d         = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Release takes priority so a simultaneous expiry never pulses timeout.
                if (!bus.req[id_q]) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (MAX_HOLD != 0 && cnt_q == CNT_W'(MAX_HOLD)) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (MAX_HOLD != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = id_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;
endmodule
